// File: rtl/agg_pkg.sv
// Shared constants and helpers for the stream aggregator.
//   AggDataWidth / AggFetchWidth : default element width and maximum lane count
//   agg_cnt_width()              : width of a lane-count field for a given lane count
//   agg_clamp_fw()               : maps a requested lane count onto 1..max_fw
package agg_pkg;

  localparam int unsigned AggDataWidth  = 16;
  localparam int unsigned AggFetchWidth = 40;

  function automatic int unsigned agg_cnt_width(input int unsigned fetch_width);
    return $clog2(fetch_width + 1);
  endfunction

  // Zero or out-of-range requests select the full word.
  function automatic int unsigned agg_clamp_fw(input int unsigned req, input int unsigned max_fw);
    return ((req == 0) || (req > max_fw)) ? max_fw : req;
  endfunction

endpackage

// File: rtl/agg_out_reg.sv
// Output holding register of the stream aggregator.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   load_i         : capture load_data_i/load_count_i (only asserted while free_o)
//   full_n_i       : downstream can accept
//   free_o         : register is empty or is being emptied this cycle
//   enq_o          : held word transfers downstream this cycle
//   data_o/count_o : held word and its valid-lane count, stable while stalled
module agg_out_reg
  import agg_pkg::*;
#(
  parameter int unsigned DataWidth  = AggDataWidth,
  parameter int unsigned FetchWidth = AggFetchWidth,
  parameter int unsigned CntW       = agg_cnt_width(FetchWidth)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          load_i,
  input  logic [FetchWidth*DataWidth-1:0] load_data_i,
  input  logic [CntW-1:0]               load_count_i,
  input  logic                          full_n_i,
  output logic                          free_o,
  output logic                          enq_o,
  output logic [FetchWidth*DataWidth-1:0] data_o,
  output logic [CntW-1:0]               count_o
);

  logic                           valid_q, valid_d;
  logic [FetchWidth*DataWidth-1:0] data_q, data_d;
  logic [CntW-1:0]                count_q, count_d;

  assign enq_o   = valid_q && full_n_i;
  assign free_o  = !valid_q || enq_o;
  assign data_o  = data_q;
  assign count_o = count_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (enq_o) begin
      valid_d = 1'b0;
    end
    // A load in the same cycle as a transfer refills the register back-to-back.
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      count_d = load_count_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stream_aggregator.sv
// Serial-to-parallel packer: dequeues one DATA_WIDTH element per cycle from an upstream
// FIFO and packs them into words of fw (1..FETCH_WIDTH, runtime selectable) lanes.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   sender_data/empty_n/deq        : upstream FIFO head, non-empty flag, dequeue strobe
//   receiver_data/count/full_n/enq : packed word, valid lanes, downstream ready, transfer
//   change_fetch_width, input_fetch_width : request a new lane count (applied between words)
//   flush                          : emit the current partial word
// Build option AGG_ZERO_PAD_EN: lanes at or above receiver_count read zero instead of
// stale data from earlier words.
module stream_aggregator
  import agg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = AggDataWidth,
  parameter int unsigned FETCH_WIDTH = AggFetchWidth,
  // Derived; do not override.
  parameter int unsigned CNT_W       = agg_cnt_width(FETCH_WIDTH)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             sender_data,
  input  logic                              sender_empty_n,
  output logic                              sender_deq,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
  output logic [CNT_W-1:0]                  receiver_count,
  input  logic                              receiver_full_n,
  output logic                              receiver_enq,
  input  logic                              change_fetch_width,
  input  logic [CNT_W-1:0]                  input_fetch_width,
  input  logic                              flush
);

  localparam int unsigned LaneBits = FETCH_WIDTH * DATA_WIDTH;

  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    fw_q, fw_d;
  logic [CNT_W-1:0]    wchg_val_q, wchg_val_d;
  logic                wchg_pend_q, wchg_pend_d;
  logic                flush_pend_q, flush_pend_d;
  logic [LaneBits-1:0] lanes_q, lanes_d;
  logic [LaneBits-1:0] word;

  logic             out_free;
  logic             last;
  logic             complete;
  logic             flush_served;
  logic             flush_emit;
  logic             wchg_apply;
  logic             load;
  logic [CNT_W-1:0] fill;

  assign last = (count_q == (fw_q - CNT_W'(1)));

  // A pending flush with data must not grow the partial word while the output is busy.
  assign sender_deq = sender_empty_n && (!last || out_free) &&
                      !(flush_pend_q && (count_q != '0) && !out_free);

  assign complete     = sender_deq && last;
  assign flush_served = flush_pend_q && out_free && !complete;
  // Lanes occupied once this cycle's element (if any) is written.
  assign fill         = count_q + CNT_W'(sender_deq);
  assign flush_emit   = flush_served && (fill != '0);
  assign load         = complete || flush_emit;
  // Width changes wait for an empty buffer so the word in progress keeps its old width.
  assign wchg_apply   = wchg_pend_q && (count_q == '0) && !sender_deq;

  always_comb begin
    word = lanes_q;
    if (sender_deq) begin
      word[int'(count_q)*DATA_WIDTH +: DATA_WIDTH] = sender_data;
    end

    lanes_d = word;
    count_d = count_q;
    if (load) begin
      count_d = '0;
`ifdef AGG_ZERO_PAD_EN
      lanes_d = '0;
`endif
    end else if (sender_deq) begin
      count_d = count_q + CNT_W'(1);
    end

    // A completing word absorbs any flush: the buffer it leaves behind is empty.
    flush_pend_d = (flush_pend_q && !(flush_served || complete)) || (flush && !complete);

    fw_d        = fw_q;
    wchg_pend_d = wchg_pend_q;
    wchg_val_d  = wchg_val_q;
    if (wchg_apply) begin
      fw_d        = wchg_val_q;
      wchg_pend_d = 1'b0;
    end
    // A newer request overwrites any pending one.
    if (change_fetch_width) begin
      wchg_pend_d = 1'b1;
      wchg_val_d  = CNT_W'(agg_clamp_fw(32'(input_fetch_width), FETCH_WIDTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      fw_q         <= CNT_W'(FETCH_WIDTH);
      wchg_val_q   <= CNT_W'(FETCH_WIDTH);
      wchg_pend_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      lanes_q      <= '0;
    end else begin
      count_q      <= count_d;
      fw_q         <= fw_d;
      wchg_val_q   <= wchg_val_d;
      wchg_pend_q  <= wchg_pend_d;
      flush_pend_q <= flush_pend_d;
      lanes_q      <= lanes_d;
    end
  end

  agg_out_reg #(
    .DataWidth  (DATA_WIDTH),
    .FetchWidth (FETCH_WIDTH),
    .CntW       (CNT_W)
  ) u_out_reg (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_i       (load),
    .load_data_i  (word),
    .load_count_i (fill),
    .full_n_i     (receiver_full_n),
    .free_o       (out_free),
    .enq_o        (receiver_enq),
    .data_o       (receiver_data),
    .count_o      (receiver_count)
  );

endmodule
